uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter for the Riscv151 memory-mapped I/O path. It is the on-chip end that drives FPGA_SERIAL_TX toward the host.
- Accepts bytes from the CPU over a ready/valid handshake and queues them in a small FIFO.
- Serializes queued bytes as 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) at a fixed baud rate.
- Back-to-back bytes go out as contiguous frames, so BIOS output strings stream without CPU polling per bit.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in baud.
- FIFO_DEPTH, 8, number of byte entries; power of two, minimum 2.

Ports:
- clk  input  1  core clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  producer has a byte on data_in.
- data_in_ready  output  1  FIFO can accept a byte this cycle.
- serial_out  output  1  UART TX line; idle high.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, not counting the byte being shifted.
- busy  output  1  high while a frame is in progress or fifo_count != 0.

Behaviour:
- Reset: one clk edge with rst=1 sets the following state:
  - serial_out=1, state=IDLE, FIFO empty (pointers 0, fifo_count=0), busy=0, data_in_ready=1, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame: serial_out is 1 after the reset edge, and all queued bytes are discarded.
- Bit time: T = CLOCK_FREQ/BAUD_RATE, integer-truncated (434 at the defaults).
  - Every bit, including start and stop, is held exactly T cycles.
  - One frame is 10*T cycles.
- Push: a byte is written when data_in_valid && data_in_ready at a rising edge.
  - data_in_ready = (fifo_count < FIFO_DEPTH), computed combinationally from the registered count.
  - When full, data_in_ready=0 even if a pop occurs in the same cycle; there is no bypass.
  - Valid while not ready has no effect and nothing is dropped internally.
- Pop: occurs only in IDLE (FIFO non-empty) or at the final cycle of STOP (FIFO non-empty).
  - A simultaneous push and pop leaves fifo_count unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: serial_out=1. If fifo_count>0, pop into the shift register and go to START.
  - START: serial_out=0 for T cycles, then go to DATA with bit index 0.
  - DATA: serial_out=shift[0] for T cycles per bit, shift right; after bit 7, go to STOP.
  - STOP: serial_out=1 for T cycles. On the last cycle, if fifo_count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: handshake at edge N with the FIFO empty and state IDLE means:
  - fifo_count=1 after edge N;
  - the pop happens at edge N+1, and serial_out=0 after edge N+1;
  - the first data bit appears after edge N+1+T.
- serial_out is driven from a register, so it is glitch-free.
- busy = (state != IDLE) || (fifo_count != 0). busy falls on the cycle after the last stop bit completes.
- Byte order on the line is exactly push order: no loss, no duplication.

Test Plan:
1. Reset behaviour: hold rst 10 cycles, then idle 1000 cycles with valid=0. Required: serial_out=1, data_in_ready=1, fifo_count=0 and busy=0 throughout.
2. Single byte: push 0x55 at edge N. Required:
   - serial_out falls after edge N+1.
   - Mid-bit sampling every 434 cycles reads 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop).
   - busy drops 4340 cycles after the start edge.
3. Prompt string: push 0x0d,0x0a,0x31,0x35,0x31,0x3e,0x20 ("\r\n151> ") on consecutive cycles. Required:
   - A bench receiver model, sampling at half-baud (BAUD_PERIOD/2), decodes exactly that sequence.
   - Each new start bit begins on the cycle right after the previous stop bit ends.
   - Total line activity is 7*4340 cycles.
4. Backpressure: hold valid high and push the 12 bytes 0x00..0x0b. Required:
   - data_in_ready deasserts when fifo_count=8.
   - It reasserts within one cycle of each pop.
   - All 12 bytes are received in order, none dropped or repeated.
5. Reset mid-frame: queue 0xa5, 0x11, 0x22; assert rst for 1 cycle during data bit 3 of 0xa5. Required:
   - serial_out=1 and fifo_count=0 on the next cycle, and no further frames are sent.
   - A subsequent push of 0x3a is transmitted correctly.
6. Simultaneous push/pop: with fifo_count=1, push 0x7e on the final cycle of STOP. Required:
   - fifo_count stays 1.
   - The queued byte is sent next, then 0x7e.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO with a ready/valid push port feeds
// a serializer that sends back-to-back frames with no idle gap between them.
module uart_tx_fifo #(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic                          serial_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int unsigned BIT_T   = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W   = (BIT_T > 1) ? $clog2(BIT_T) : 1;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned COUNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_T - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift, shift_n;
   logic             serial_n;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             push, pop, bit_done;

   assign data_in_ready = fifo_count < COUNT_W'(FIFO_DEPTH);
   assign push          = data_in_valid && data_in_ready;
   assign busy          = (state != IDLE) || (fifo_count != '0);
   assign bit_done      = (baud_cnt == CNT_LAST);

   // Next-state, next line level and FIFO pop decision
   always_comb begin
      state_n    = state;
      baud_cnt_n = bit_done ? '0 : baud_cnt + CNT_W'(1);
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      serial_n   = serial_out;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            serial_n   = 1'b1;
            if (fifo_count != '0) begin
               pop      = 1'b1;
               shift_n  = mem[rd_ptr];
               state_n  = START;
               serial_n = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_n   = DATA;
               bit_idx_n = 3'd0;
               serial_n  = shift[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == 3'd7) begin
                  state_n  = STOP;
                  serial_n = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  shift_n   = {1'b0, shift[7:1]};
                  serial_n  = shift[1];
               end
            end
         end
         STOP: begin
            // Chain straight into the next start bit when more data is queued
            if (bit_done) begin
               if (fifo_count != '0) begin
                  pop      = 1'b1;
                  shift_n  = mem[rd_ptr];
                  state_n  = START;
                  serial_n = 1'b0;
               end else begin
                  state_n  = IDLE;
                  serial_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, serializer and FIFO bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         serial_out <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         state      <= state_n;
         baud_cnt   <= baud_cnt_n;
         bit_idx    <= bit_idx_n;
         shift      <= shift_n;
         serial_out <= serial_n;
         wr_ptr     <= wr_ptr + PTR_W'(push);
         rd_ptr     <= rd_ptr + PTR_W'(pop);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + COUNT_W'(1);
            2'b01:   fifo_count <= fifo_count - COUNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-position reference model, half-baud receiver,
// directed scenarios plus a randomized push/reset phase.
module tb_uart_tx_fifo;

   localparam int unsigned CF    = 1_000_000;
   localparam int unsigned BR    = 83_333;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned T     = CF / BR;   // 12 after truncation
   localparam int unsigned FRAME = 10 * T;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic data_in_valid = 1'b0;
   logic data_in_ready;
   logic serial_out;
   logic [$clog2(DEPTH):0] fifo_count;
   logic busy;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .serial_out(serial_out),
      .fifo_count(fifo_count), .busy(busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int stall_cnt = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event absent, expected it (cycle %0d)", name, cyc);
   endtask

   // Reference model: queue of bytes plus position inside the current frame
   logic [7:0] q[$];
   logic [7:0] rx_exp[$];
   bit         m_active = 1'b0;
   int         m_t = 0;
   logic [7:0] m_cur = 8'h00;
   bit         rx_abort = 1'b0;
   bit         push_ok, do_pop;

   function automatic logic exp_line();
      int b;
      if (!m_active) return 1'b1;
      b = m_t / T;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         q.delete();
         rx_exp.delete();
         m_active = 1'b0;
         m_t = 0;
         rx_abort = 1'b1;
      end else begin
         push_ok = data_in_valid && (q.size() < DEPTH);
         do_pop  = (q.size() > 0) && (!m_active || m_t == FRAME - 1);
         if (do_pop) begin
            m_cur = q.pop_front();
            m_active = 1'b1;
            m_t = 0;
         end else if (m_active) begin
            if (m_t == FRAME - 1) m_active = 1'b0;
            else m_t++;
         end
         if (push_ok) begin
            q.push_back(data_in);
            rx_exp.push_back(data_in);
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("serial_out", 32'(serial_out), 32'(exp_line()));
         chk("fifo_count", 32'(fifo_count), 32'(q.size()));
         chk("data_in_ready", 32'(data_in_ready), 32'(q.size() < DEPTH));
         chk("busy", 32'(busy), 32'(m_active || q.size() != 0));
      end
   end

   // Line receiver sampling each bit at its midpoint
   bit         rx_active = 1'b0;
   int         rx_t = 0;
   int         rx_k;
   logic [7:0] rx_byte;
   logic [7:0] rx_log[$];
   int         rx_starts[$];

   always @(negedge clk) begin
      if (rx_abort) begin
         rx_active = 1'b0;
         rx_abort  = 1'b0;
      end else if (chk_en) begin
         if (!rx_active) begin
            if (serial_out === 1'b0) begin
               rx_active = 1'b1;
               rx_t = 0;
               rx_starts.push_back(cyc);
            end
         end else begin
            rx_t++;
         end
         if (rx_active && (rx_t % T) == T / 2) begin
            rx_k = rx_t / T;
            if (rx_k == 0) chk("rx_start_bit", 32'(serial_out), 32'd0);
            else if (rx_k <= 8) rx_byte[rx_k-1] = serial_out;
            else begin
               chk("rx_stop_bit", 32'(serial_out), 32'd1);
               if (rx_exp.size() == 0) fail_now("rx_extra_byte");
               else chk("rx_byte_order", 32'(rx_byte), 32'(rx_exp.pop_front()));
               rx_log.push_back(rx_byte);
               rx_active = 1'b0;
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      int w = 0;
      data_in = b;
      data_in_valid = 1'b1;
      while (!data_in_ready && w < 2000) begin
         stall_cnt++;
         chk("ready_low_only_when_full", 32'(fifo_count), DEPTH);
         @(negedge clk);
         w++;
      end
      if (w >= 2000) fail_now("push_timeout");
      @(negedge clk);
      data_in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      while (busy !== 1'b0 && w < 50000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50000) fail_now("idle_timeout");
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_logs();
      rx_log.delete();
      rx_starts.delete();
   endtask

   logic [9:0] pat55 = 10'b1010101010;
   logic [7:0] prompt [7] = '{8'h0d, 8'h0a, 8'h31, 8'h35, 8'h31, 8'h3e, 8'h20};
   logic [7:0] t6_seq [3] = '{8'h41, 8'h42, 8'h7e};
   int s_cyc, nst, w;

   initial begin
      // Reset and long idle
      @(negedge clk);
      chk_en = 1'b1;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      repeat (1000) @(negedge clk);
      chk("t1_serial", 32'(serial_out), 32'd1);
      chk("t1_ready", 32'(data_in_ready), 32'd1);
      chk("t1_count", 32'(fifo_count), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);

      // Single byte 0x55 with literal bit pattern and busy timing
      clear_logs();
      push_byte(8'h55);
      chk("t2_line_before_pop", 32'(serial_out), 32'd1);
      chk("t2_count_after_push", 32'(fifo_count), 32'd1);
      @(negedge clk);
      chk("t2_start_fall", 32'(serial_out), 32'd0);
      repeat (T / 2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         chk("t2_midbit", 32'(serial_out), 32'(pat55[k]));
         if (k < 9) repeat (T) @(negedge clk);
      end
      repeat (T / 2 - 1) @(negedge clk);
      chk("t2_busy_last_stop", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t2_busy_drop", 32'(busy), 32'd0);
      wait_idle();

      // Prompt string, contiguous frames
      clear_logs();
      for (int i = 0; i < 7; i++) push_byte(prompt[i]);
      wait_idle();
      chk("t3_rx_count", 32'(rx_log.size()), 32'd7);
      for (int i = 0; i < 7; i++)
         if (i < rx_log.size()) chk("t3_rx_char", 32'(rx_log[i]), 32'(prompt[i]));
      if (rx_starts.size() == 7) begin
         for (int i = 1; i < 7; i++)
            chk("t3_frame_gap", 32'(rx_starts[i] - rx_starts[i-1]), FRAME);
         chk("t3_total_activity", 32'(rx_starts[6] + FRAME - rx_starts[0]), 7 * FRAME);
      end else fail_now("t3_start_count");

      // Backpressure with 12 bytes
      clear_logs();
      stall_cnt = 0;
      for (int i = 0; i < 12; i++) push_byte(8'(i));
      chk("t4_saw_backpressure", 32'(stall_cnt > 0), 32'd1);
      wait_idle();
      chk("t4_rx_count", 32'(rx_log.size()), 32'd12);
      for (int i = 0; i < 12; i++)
         if (i < rx_log.size()) chk("t4_rx_byte", 32'(rx_log[i]), 32'(i));

      // Reset during data bit 3 of 0xa5
      clear_logs();
      push_byte(8'ha5);
      push_byte(8'h11);
      push_byte(8'h22);
      w = 0;
      while (rx_starts.size() == 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (rx_starts.size() == 0) fail_now("t5_no_start");
      else begin
         s_cyc = rx_starts[0];
         while (cyc < s_cyc + 4 * T + 2) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         chk("t5_serial_after_rst", 32'(serial_out), 32'd1);
         chk("t5_count_after_rst", 32'(fifo_count), 32'd0);
         chk("t5_busy_after_rst", 32'(busy), 32'd0);
         nst = rx_starts.size();
         repeat (3 * FRAME) @(negedge clk);
         chk("t5_no_more_frames", 32'(rx_starts.size()), 32'(nst));
         push_byte(8'h3a);
         wait_idle();
         chk("t5_rx_count", 32'(rx_log.size()), 32'd1);
         if (rx_log.size() > 0) chk("t5_rx_byte", 32'(rx_log[0]), 32'h3a);
      end

      // Push on the final STOP cycle while one byte is queued
      clear_logs();
      push_byte(8'h41);
      push_byte(8'h42);
      s_cyc = cyc;
      chk("t6_first_start", 32'(serial_out), 32'd0);
      chk("t6_count_before", 32'(fifo_count), 32'd1);
      while (cyc < s_cyc + FRAME - 1) @(negedge clk);
      chk("t6_in_stop", 32'(serial_out), 32'd1);
      data_in = 8'h7e;
      data_in_valid = 1'b1;
      @(negedge clk);
      data_in_valid = 1'b0;
      chk("t6_count_same", 32'(fifo_count), 32'd1);
      chk("t6_next_start", 32'(serial_out), 32'd0);
      wait_idle();
      chk("t6_rx_count", 32'(rx_log.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < rx_log.size()) chk("t6_rx_byte", 32'(rx_log[i]), 32'(t6_seq[i]));

      // Randomized pushes with occasional resets
      for (int i = 0; i < 3000; i++) begin
         data_in = 8'($urandom);
         data_in_valid = ($urandom_range(3) == 0);
         rst = ($urandom_range(699) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      data_in_valid = 1'b0;
      wait_idle();
      repeat (T) @(negedge clk);
      chk("all_bytes_delivered", 32'(rx_exp.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
